decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe_pkg.sv | 21 ++
 rtl/decode_scoreboard.sv | 85 ++++++++
 rtl/decode_pipe.sv | 130 +++++++++++++
 tb/tb_decode_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pipe_pkg.sv
// Shared defaults and the decode output payload layout for decode_pipe.
// No ports. The payload struct is laid out at the default widths and is
// the reference shape of one decoded instruction as seen on the outputs.
package decode_pipe_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREG   = 8;
  localparam int DEF_CTRL_W = 24;
  localparam int DEF_PEND_W = 2;
  localparam int DEF_RA_W   = $clog2(DEF_NREG);

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rd1;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] imm;
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_RA_W-1:0]   rd;
    logic                  we;
  } payload_t;

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register in-flight write tracking for decode_pipe.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rs, rt, rd          register selects of the instruction being offered
//   rs_used, rt_used,   source-use flags and write flag of that instruction
//   we
//   issue               instruction with a destination write accepted this cycle
//   wb_en, wb_sel       writeback retiring one in-flight write
//   squash, squash_rd   held instruction with a write discarded by flush
//   hazard              offered instruction must stall
//   err                 sticky: writeback arrived with nothing in flight
// Macro DECODE_PIPE_BYPASS_EN: a same-cycle writeback clears a source dependency.
module decode_scoreboard
  import decode_pipe_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int PEND_W = DEF_PEND_W,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] rt,
  input  logic [RA_W-1:0] rd,
  input  logic            rs_used,
  input  logic            rt_used,
  input  logic            we,
  input  logic            issue,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_sel,
  input  logic            squash,
  input  logic [RA_W-1:0] squash_rd,
  output logic            hazard,
  output logic            err
);

`ifdef DECODE_PIPE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend [NREG];

  // A source is busy while its effective count is non-zero; with bypass a
  // writeback landing this cycle retires one outstanding write early.
  function automatic logic busy(input logic [PEND_W-1:0] cnt, input logic wb_hit);
    return (cnt != '0) && !(BYPASS && wb_hit && cnt == PEND_W'(1));
  endfunction

  // Net counter update; decrements never go below zero and a writeback to an
  // idle counter is the error case, so it does not cancel a same-cycle issue.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                  input logic inc, input logic wb_hit,
                                                  input logic sq_hit);
    logic [PEND_W:0] up;
    logic [PEND_W:0] down;
    up   = {1'b0, cnt} + (PEND_W+1)'(inc);
    down = (PEND_W+1)'(wb_hit && cnt != '0) + (PEND_W+1)'(sq_hit);
    if (down >= up) return '0;
    up = up - down;
    return (up > {1'b0, PEND_MAX}) ? PEND_MAX : up[PEND_W-1:0];
  endfunction

  assign hazard = (rs_used && busy(pend[rs], wb_en && wb_sel == rs)) ||
                  (rt_used && busy(pend[rt], wb_en && wb_sel == rt)) ||
                  (we && pend[rd] == PEND_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        pend[i] <= pend_next(pend[i], issue && rd == RA_W'(i),
                             wb_en && wb_sel == RA_W'(i),
                             squash && squash_rd == RA_W'(i));
      end
      if (wb_en && pend[wb_sel] == '0) err <= 1'b1;
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: register file read, scoreboard interlock, one-entry output
// register with valid/ready handshakes on both sides.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   in_valid/in_ready               upstream handshake
//   in_rs, in_rt, in_rd             source and destination selects
//   in_rs_used, in_rt_used, in_we   source-use and write-enable flags
//   in_imm, in_ctrl                 pass-through payload
//   wb_en, wb_sel, wb_data          register file writeback
//   flush                           squash held and incoming instruction
//   out_valid/out_ready             downstream handshake
//   out_rd1, out_rd2, out_imm,      decoded payload
//   out_ctrl, out_rd, out_we
//   err                             sticky scoreboard error
// Macro DECODE_PIPE_BYPASS_EN: reads of the register being written this
// cycle return wb_data (undefined: stored value, one extra stall per RAW).
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int PEND_W = DEF_PEND_W,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RA_W-1:0]   in_rs,
  input  logic [RA_W-1:0]   in_rt,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_rs_used,
  input  logic              in_rt_used,
  input  logic              in_we,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_we,
  output logic              err
);

`ifdef DECODE_PIPE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              hazard;
  logic              accept;
  logic              squash;

  assign rd1 = (BYPASS && wb_en && wb_sel == in_rs) ? wb_data : regs[in_rs];
  assign rd2 = (BYPASS && wb_en && wb_sel == in_rt) ? wb_data : regs[in_rt];

  // rst gates in_ready so nothing is offered as accepted while held in reset.
  assign in_ready = rst && (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  // A held write discarded by flush gives its in-flight slot back; if it is
  // consumed in the same cycle it stays in flight.
  assign squash   = flush && out_valid && out_we && !out_ready;

  decode_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .rs_used   (in_rs_used),
    .rt_used   (in_rt_used),
    .we        (in_we),
    .issue     (accept && in_we),
    .wb_en     (wb_en),
    .wb_sel    (wb_sel),
    .squash    (squash),
    .squash_rd (out_rd),
    .hazard    (hazard),
    .err       (err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_sel] <= wb_data;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_rd1   <= '0;
      out_rd2   <= '0;
      out_imm   <= '0;
      out_ctrl  <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_rd1  <= rd1;
        out_rd2  <= rd2;
        out_imm  <= in_imm;
        out_ctrl <= in_ctrl;
        out_rd   <= in_rd;
        out_we   <= in_we;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
`timescale 1ns/1ps
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int CTRL_W = 24;
  localparam int PEND_W = 2;
  localparam int RA_W   = 3;
  localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef DECODE_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [RA_W-1:0]   in_rs, in_rt, in_rd;
  logic              in_rs_used, in_rt_used, in_we;
  logic [DATA_W-1:0] in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic              wb_en;
  logic [RA_W-1:0]   wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_rd1, out_rd2, out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RA_W-1:0]   out_rd;
  logic              out_we;
  logic              err;

  decode_pipe #(.DATA_W(DATA_W), .NREG(NREG), .CTRL_W(CTRL_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_used(in_rs_used), .in_rt_used(in_rt_used), .in_we(in_we),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_rd(out_rd), .out_we(out_we), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: architectural registers, outstanding writes per register,
  // whether an instruction is held downstream, and the expected output stream.
  logic [DATA_W-1:0] m_regs [NREG];
  int                m_pend [NREG];
  bit                m_valid, m_err;
  logic [RA_W-1:0]   m_held_rd;
  bit                m_held_we;
  payload_t          exp_q[$];
  payload_t          mon_act, mon_exp;

  function automatic payload_t dut_payload();
    payload_t p;
    p.rd1 = out_rd1; p.rd2 = out_rd2; p.imm = out_imm;
    p.ctrl = out_ctrl; p.rd = out_rd; p.we = out_we;
    return p;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_pend[r] = 0; end
    m_valid = 0; m_err = 0; m_held_rd = '0; m_held_we = 0;
    exp_q.delete();
  endtask

  task automatic idle();
    in_valid = 0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_rs_used = 0; in_rt_used = 0; in_we = 0; in_imm = '0; in_ctrl = '0;
    wb_en = 0; wb_sel = '0; wb_data = '0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input int rs, input int rt, input int rd,
                       input bit rsu, input bit rtu, input bit we);
    in_valid = 1; in_rs = RA_W'(rs); in_rt = RA_W'(rt); in_rd = RA_W'(rd);
    in_rs_used = rsu; in_rt_used = rtu; in_we = we;
    in_imm = DATA_W'($urandom); in_ctrl = CTRL_W'($urandom);
  endtask

  // Called 2 time units after a rising edge with inputs already driven;
  // returns 2 time units after the next rising edge.
  task automatic step();
    int       eff_rs, eff_rt, d;
    bit       haz, exp_rdy, acc, sq;
    int       newp [NREG];
    payload_t p;
    #1;
    eff_rs = m_pend[in_rs] - ((BYP && wb_en && wb_sel == in_rs && m_pend[in_rs] > 0) ? 1 : 0);
    eff_rt = m_pend[in_rt] - ((BYP && wb_en && wb_sel == in_rt && m_pend[in_rt] > 0) ? 1 : 0);
    haz = (in_rs_used && eff_rs > 0) || (in_rt_used && eff_rt > 0) ||
          (in_we && m_pend[in_rd] >= PMAX);
    exp_rdy = (!m_valid || out_ready) && !haz && !flush;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    acc = in_valid && exp_rdy;
    sq  = flush && m_valid && !out_ready;
    if (acc) begin
      p.rd1  = (BYP && wb_en && wb_sel == in_rs) ? wb_data : m_regs[in_rs];
      p.rd2  = (BYP && wb_en && wb_sel == in_rt) ? wb_data : m_regs[in_rt];
      p.imm  = in_imm; p.ctrl = in_ctrl; p.rd = in_rd; p.we = in_we;
    end
    for (int r = 0; r < NREG; r++) begin
      d = 0;
      if (acc && in_we && in_rd == RA_W'(r)) d++;
      if (wb_en && wb_sel == RA_W'(r) && m_pend[r] > 0) d--;
      if (sq && m_held_we && m_held_rd == RA_W'(r)) d--;
      newp[r] = m_pend[r] + d;
      if (newp[r] < 0) newp[r] = 0;
      if (newp[r] > PMAX) newp[r] = PMAX;
    end
    if (wb_en && m_pend[wb_sel] == 0) m_err = 1;
    for (int r = 0; r < NREG; r++) m_pend[r] = newp[r];
    if (wb_en) m_regs[wb_sel] = wb_data;
    if (sq && exp_q.size() > 0) void'(exp_q.pop_front());
    if (flush)          m_valid = 0;
    else if (acc)       m_valid = 1;
    else if (out_ready) m_valid = 0;
    if (acc) begin
      exp_q.push_back(p);
      m_held_rd = in_rd; m_held_we = in_we;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    chk("err", 128'(err), 128'(m_err));
    #1;
  endtask

  task automatic do_reset();
    rst = 0; idle();
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_payload", 128'(dut_payload()), 128'(0));
    model_clear();
    @(posedge clk);
    #2;
    rst = 1;
  endtask

  task automatic rand_cycle(input bit allow_flush);
    int cand[$];
    in_valid = ($urandom_range(3) != 0);
    in_rs = RA_W'($urandom_range(NREG - 1));
    in_rt = RA_W'($urandom_range(NREG - 1));
    in_rd = RA_W'($urandom_range(NREG - 1));
    in_rs_used = $urandom_range(1) != 0;
    in_rt_used = $urandom_range(1) != 0;
    in_we = $urandom_range(1) != 0;
    in_imm = DATA_W'($urandom); in_ctrl = CTRL_W'($urandom);
    wb_en = 0; wb_sel = '0; wb_data = DATA_W'($urandom);
    for (int r = 0; r < NREG; r++) if (m_pend[r] > 0) cand.push_back(r);
    if (cand.size() > 0 && $urandom_range(2) != 0) begin
      wb_en = 1;
      wb_sel = RA_W'(cand[$urandom_range(cand.size() - 1)]);
    end
    flush = allow_flush && ($urandom_range(15) == 0);
    out_ready = ($urandom_range(3) != 0);
    step();
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      int sel = -1;
      idle();
      for (int r = NREG - 1; r >= 0; r--) if (m_pend[r] > 0) sel = r;
      if (sel < 0) break;
      wb_en = 1; wb_sel = RA_W'(sel); wb_data = DATA_W'($urandom);
      step();
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever both valid
  // and ready are high here; compare against the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid && out_ready) begin
      mon_act = dut_payload();
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL out_unexpected: got %0h expected no output", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_payload", 128'(mon_act), 128'(mon_exp));
      end
    end
  end

  initial begin
    rst = 0; idle(); model_clear();
    @(posedge clk); #2;
    do_reset();

    // producers for r1/r2, then writebacks r1=5, r2=7, then rs=1,rt=2,rd=3
    issue(0, 0, 1, 0, 0, 1); step();
    issue(0, 0, 2, 0, 0, 1); step();
    idle(); wb_en = 1; wb_sel = 3'd1; wb_data = 16'd5; step();
    idle(); wb_en = 1; wb_sel = 3'd2; wb_data = 16'd7; step();
    idle(); issue(1, 2, 3, 1, 1, 1); step();
    idle(); step();

    // RAW on r3: stall, then writeback of 0x00AA releases it
    idle(); issue(3, 0, 0, 1, 0, 0); step();
    wb_en = 1; wb_sel = 3'd3; wb_data = 16'h00AA; step();
    wb_en = 0; step();
    idle(); step(); step();

    // destination counter saturation on r4
    for (int k = 0; k < 3; k++) begin idle(); issue(0, 0, 4, 0, 0, 1); step(); end
    idle(); issue(0, 0, 4, 0, 0, 1); step();
    wb_en = 1; wb_sel = 3'd4; wb_data = DATA_W'($urandom); step();
    wb_en = 0; step();
    drain();

    // downstream backpressure for 4 cycles
    idle(); issue(5, 6, 0, 0, 0, 0); step();
    issue(1, 2, 7, 0, 0, 0); out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_payload", 128'(dut_payload()), 128'(exp_q[0]));
    end
    out_ready = 1; step();
    idle(); step();

    // flush of a held write to r6
    idle(); issue(0, 0, 6, 0, 0, 1); step();
    issue(6, 0, 1, 1, 0, 0); out_ready = 0; flush = 1; step();
    flush = 0; out_ready = 1; step();
    idle(); step();

    // random traffic, a reset in the middle, more random traffic
    for (int k = 0; k < 300; k++) rand_cycle(1);
    do_reset();
    for (int k = 0; k < 300; k++) rand_cycle(1);
    drain();
    idle(); step(); step();

    // writeback with nothing in flight sets the sticky error
    idle(); wb_en = 1; wb_sel = 3'd5; wb_data = 16'h1234; step();
    idle();
    for (int k = 0; k < 3; k++) step();
    chk("err_sticky", 128'(err), 128'(1));
    do_reset();
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
